pipeline_ctrl: RTL and testbench

- Central stall/flush sequencer for the rv32imc 5-stage pipeline.
- Merges the load-use hazard request, data-memory wait, multi-cycle mul/div occupancy, instruction-fetch miss and EX-stage control-flow redirects.
- Produces per-stage register write enables, bubble-injection flushes and a redirect handshake to fetch.
- Also keeps a redirect-pending buffer, a mul/div watchdog and a stall-cycle performance counter.

---
 rtl/pipeline_ctrl_if.sv | 47 ++++
 rtl/pipeline_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: hazard/status inputs toward the sequencer, stage enables,
// flushes and the fetch redirect handshake back out. Pure wiring, no latency.
interface pipeline_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             load_use_hazard;
  logic             mem_req;
  logic             dmem_resp;
  logic             imem_resp;
  logic             ex_muldiv;
  logic             muldiv_done;
  logic             ex_redirect;
  logic [XLEN-1:0]  ex_redirect_pc;
  logic             redirect_ready;

  logic             pc_we;
  logic             if_id_we;
  logic             id_ex_we;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_cycles;

  // Sequencer side
  modport master (
    input  load_use_hazard, mem_req, dmem_resp, imem_resp, ex_muldiv, muldiv_done,
           ex_redirect, ex_redirect_pc, redirect_ready,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, ex_mem_flush,
           redirect_valid, redirect_pc, md_timeout, stall_cycles
  );

  // Pipeline / fetch side
  modport slave (
    output load_use_hazard, mem_req, dmem_resp, imem_resp, ex_muldiv, muldiv_done,
           ex_redirect, ex_redirect_pc, redirect_ready,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, ex_mem_flush,
           redirect_valid, redirect_pc, md_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: enables and flushes are combinational (same cycle);
// a redirect not accepted by fetch is held in a one-entry buffer until redirect_ready.
module pipeline_ctrl #(
  parameter int XLEN       = 32,
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input logic              clk,
  input logic              rst_n,
  pipeline_ctrl_if.master  bus
);
  localparam int MDC_W = $clog2(MD_TIMEOUT + 1);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  md_state_t        md_state, md_state_nxt;
  logic [MDC_W-1:0] md_cnt, md_cnt_nxt;
  logic             md_timeout_q;
  logic             pend, pend_nxt;
  logic [XLEN-1:0]  pend_pc, pend_pc_nxt;
  logic [CNT_W-1:0] stall_q;

  logic             dm_stall, md_stall, redir_take, pend_serve;
  logic             pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic             if_id_flush, id_ex_flush, ex_mem_flush;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;

  assign dm_stall   = bus.mem_req & ~bus.dmem_resp;
  assign md_stall   = bus.ex_muldiv & ~bus.muldiv_done;
  assign redir_take = bus.ex_redirect & ~dm_stall & ~md_stall & ~pend;
  // Pending redirect is only served when nothing freezes the PC
  assign pend_serve = pend & ~dm_stall & ~md_stall;

  always_comb begin
    pc_we          = 1'b1;
    if_id_we       = 1'b1;
    id_ex_we       = 1'b1;
    ex_mem_we      = 1'b1;
    mem_wb_we      = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_flush   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (dm_stall) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
    end else if (md_stall) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (redir_take) begin
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = bus.ex_redirect_pc;
      pc_we          = bus.redirect_ready;
    end else if (pend_serve) begin
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = pend_pc;
      pc_we          = bus.redirect_ready;
    end else if (bus.load_use_hazard) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (!bus.imem_resp) begin
      pc_we       = 1'b0;
      if_id_flush = 1'b1;
    end
    // Outputs are quiet for the whole reset window, not just at the edge
    if (!rst_n) begin
      pc_we          = 1'b0;
      if_id_we       = 1'b0;
      id_ex_we       = 1'b0;
      ex_mem_we      = 1'b0;
      mem_wb_we      = 1'b0;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      ex_mem_flush   = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end
  end

  always_comb begin
    pend_nxt    = pend;
    pend_pc_nxt = pend_pc;
    if (redir_take && !bus.redirect_ready) begin
      pend_nxt    = 1'b1;
      pend_pc_nxt = bus.ex_redirect_pc;
    end
    if (pend_serve && bus.redirect_ready) begin
      pend_nxt = 1'b0;
    end
  end

  always_comb begin
    md_state_nxt = md_state;
    md_cnt_nxt   = md_cnt;
    case (md_state)
      MD_IDLE: begin
        if (md_stall && !dm_stall) begin
          md_state_nxt = MD_BUSY;
          md_cnt_nxt   = MDC_W'(1);
        end
      end
      MD_BUSY: begin
        if (!dm_stall) begin
          if (bus.muldiv_done || !bus.ex_muldiv) begin
            md_state_nxt = MD_IDLE;
            md_cnt_nxt   = '0;
          end else if (md_cnt != MDC_W'(MD_TIMEOUT)) begin
            md_cnt_nxt = md_cnt + MDC_W'(1);
          end
        end
      end
      default: begin
        md_state_nxt = MD_IDLE;
        md_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_state     <= MD_IDLE;
      md_cnt       <= '0;
      md_timeout_q <= 1'b0;
      pend         <= 1'b0;
      pend_pc      <= '0;
      stall_q      <= '0;
    end else begin
      md_state <= md_state_nxt;
      md_cnt   <= md_cnt_nxt;
      pend     <= pend_nxt;
      pend_pc  <= pend_pc_nxt;
      if (md_state == MD_BUSY && md_cnt == MDC_W'(MD_TIMEOUT)) begin
        md_timeout_q <= 1'b1;
      end
      if (!pc_we && stall_q != {CNT_W{1'b1}}) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc_we          = pc_we;
  assign bus.if_id_we       = if_id_we;
  assign bus.id_ex_we       = id_ex_we;
  assign bus.ex_mem_we      = ex_mem_we;
  assign bus.mem_wb_we      = mem_wb_we;
  assign bus.if_id_flush    = if_id_flush;
  assign bus.id_ex_flush    = id_ex_flush;
  assign bus.ex_mem_flush   = ex_mem_flush;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.md_timeout     = md_timeout_q;
  assign bus.stall_cycles   = stall_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: per-cycle expected controls are queued as stimulus is driven
// and popped/compared at the following falling edge.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.XLEN(32), .CNT_W(32)) bus ();

  pipeline_ctrl #(.XLEN(32), .MD_TIMEOUT(64), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [4:0]  we;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [2:0]  fl;   // {if_id, id_ex, ex_mem}
    logic        rv;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] obs_we();
    return {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we};
  endfunction

  function automatic logic [2:0] obs_fl();
    return {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush};
  endfunction

  task automatic set_in(input logic lu, input logic mreq, input logic dresp, input logic imem,
                        input logic mdv, input logic mdone, input logic redir,
                        input logic [31:0] rpc, input logic rdy);
    bus.load_use_hazard = lu;
    bus.mem_req         = mreq;
    bus.dmem_resp       = dresp;
    bus.imem_resp       = imem;
    bus.ex_muldiv       = mdv;
    bus.muldiv_done     = mdone;
    bus.ex_redirect     = redir;
    bus.ex_redirect_pc  = rpc;
    bus.redirect_ready  = rdy;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 1, 0, 0, 0, 32'h0, 1);
  endtask

  // Push expectation for the current cycle, compare at negedge, advance past the next posedge
  task automatic step(input string tag, input logic [4:0] we, input logic [2:0] fl,
                      input logic rv, input logic [31:0] pc);
    exp_t e;
    exp_q.push_back('{tag, we, fl, rv, pc});
    @(negedge clk);
    e = exp_q.pop_front();
    chk({e.tag, "_we"}, 64'(obs_we()), 64'(e.we));
    chk({e.tag, "_fl"}, 64'(obs_fl()), 64'(e.fl));
    chk({e.tag, "_rv"}, 64'(bus.redirect_valid), 64'(e.rv));
    if (e.rv) chk({e.tag, "_pc"}, 64'(bus.redirect_pc), 64'(e.pc));
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; asserts reset mid-cycle and checks the asynchronous effect
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rst_we"}, 64'(obs_we()), 64'h0);
    chk({tag, "_rst_fl"}, 64'(obs_fl()), 64'h0);
    chk({tag, "_rst_rv"}, 64'(bus.redirect_valid), 64'h0);
    chk({tag, "_rst_pc"}, 64'(bus.redirect_pc), 64'h0);
    chk({tag, "_rst_stall"}, 64'(bus.stall_cycles), 64'h0);
    chk({tag, "_rst_mdto"}, 64'(bus.md_timeout), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // EX cannot hold a redirect while a redirect is pending: ID/EX is flushed each pending cycle
  always @(negedge clk) begin
    if (rst_n && dut.pend) begin
      assert (!bus.ex_redirect) else $error("ex_redirect seen while redirect pending");
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    @(posedge clk);
    #1;
    do_reset("init");
    step("idle", 5'b11111, 3'b000, 0, 0);

    // Load-use bubble
    set_in(1, 0, 0, 1, 0, 0, 0, 0, 1);
    step("lu", 5'b00111, 3'b010, 0, 0);
    idle();
    step("lu_after", 5'b11111, 3'b000, 0, 0);
    chk("lu_stall_cnt", 64'(bus.stall_cycles), 64'd1);

    // Dmem wait during load-use
    do_reset("dm");
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, 1, 0, 0, 0, 0, 1);
      step("dm_freeze", 5'b00000, 3'b000, 0, 0);
    end
    set_in(1, 1, 1, 1, 0, 0, 0, 0, 1);
    step("dm_lu", 5'b00111, 3'b010, 0, 0);
    idle();
    step("dm_after", 5'b11111, 3'b000, 0, 0);
    chk("dm_stall_cnt", 64'(bus.stall_cycles), 64'd4);

    // Mul/div completing on cycle 33
    do_reset("md");
    for (int i = 1; i <= 32; i++) begin
      set_in(0, 0, 0, 1, 1, 0, 0, 0, 1);
      step("md_busy", 5'b00011, 3'b001, 0, 0);
    end
    set_in(0, 0, 0, 1, 1, 1, 0, 0, 1);
    step("md_done", 5'b11111, 3'b000, 0, 0);
    idle();
    step("md_after", 5'b11111, 3'b000, 0, 0);
    chk("md_no_timeout", 64'(bus.md_timeout), 64'd0);
    chk("md_stall_cnt", 64'(bus.stall_cycles), 64'd32);

    // Watchdog
    do_reset("wd");
    for (int i = 1; i <= 70; i++) begin
      set_in(0, 0, 0, 1, 1, 0, 0, 0, 1);
      step("wd_busy", 5'b00011, 3'b001, 0, 0);
      if (i == 60) chk("wd_not_yet", 64'(bus.md_timeout), 64'd0);
    end
    chk("wd_set", 64'(bus.md_timeout), 64'd1);
    idle();
    step("wd_drop", 5'b11111, 3'b000, 0, 0);
    step("wd_idle", 5'b11111, 3'b000, 0, 0);
    chk("wd_sticky", 64'(bus.md_timeout), 64'd1);

    // Redirect backpressure: two refused cycles then accept
    do_reset("rd");
    set_in(0, 0, 0, 1, 0, 0, 1, 32'h0000_1000, 0);
    step("rd_c1", 5'b01111, 3'b110, 1, 32'h0000_1000);
    set_in(0, 0, 0, 1, 0, 0, 0, 32'h0, 0);
    step("rd_c2", 5'b01111, 3'b110, 1, 32'h0000_1000);
    set_in(0, 0, 0, 1, 0, 0, 0, 32'h0, 1);
    step("rd_c3", 5'b11111, 3'b110, 1, 32'h0000_1000);
    idle();
    step("rd_done", 5'b11111, 3'b000, 0, 0);
    chk("rd_stall_cnt", 64'(bus.stall_cycles), 64'd2);

    // Immediate accept overrides load-use
    set_in(1, 0, 0, 1, 0, 0, 1, 32'h0000_0400, 1);
    step("rd_imm", 5'b11111, 3'b110, 1, 32'h0000_0400);
    idle();
    step("rd_imm_after", 5'b11111, 3'b000, 0, 0);

    // Fetch miss
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("imiss", 5'b01111, 3'b100, 0, 0);

    // Data-memory wait wins over a redirect; redirect follows once memory completes
    set_in(0, 1, 0, 1, 0, 0, 1, 32'h0000_2000, 1);
    step("dm_vs_rd", 5'b00000, 3'b000, 0, 0);
    set_in(0, 1, 1, 1, 0, 0, 1, 32'h0000_2000, 1);
    step("rd_after_dm", 5'b11111, 3'b110, 1, 32'h0000_2000);
    idle();
    step("rd_after_dm2", 5'b11111, 3'b000, 0, 0);
    chk("misc_stall_cnt", 64'(bus.stall_cycles), 64'd4);

    // Async reset while a redirect is pending
    set_in(0, 0, 0, 1, 0, 0, 1, 32'h0000_3000, 0);
    step("ar_c1", 5'b01111, 3'b110, 1, 32'h0000_3000);
    set_in(0, 0, 0, 1, 0, 0, 0, 32'h0, 0);
    #1;
    chk("ar_pend_before", 64'(bus.redirect_valid), 64'd1);
    do_reset("ar");
    idle();
    step("ar_after", 5'b11111, 3'b000, 0, 0);
    step("ar_after2", 5'b11111, 3'b000, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
